// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file host arbiter.
// Holds the arbiter state encoding and the counter-width helper.
package rf_arb_pkg;

  localparam int XLEN_DEF          = 32;
  localparam int AW_DEF            = 5;
  localparam int MAX_WAIT_DEF      = 8;
  localparam int STALL_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    STALL,
    ACCESS,
    RESP
  } arb_state_t;

  function automatic int ctr_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rf_arb_wait_ctr.sv
// Saturating up-counter with clear (priority) and enable; one-cycle update latency.
// tc flags that the next enabled count lands on MAX, so callers can act on that same edge.
module rf_arb_wait_ctr
  import rf_arb_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = ctr_width(MAX);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] LAST_V = W'(MAX - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt >= LAST_V);

endmodule

// File: rtl/rf_host_arbiter.sv
// Shares the decode register file between the pipeline and a host master; write port is
// combinational, host reads freeze the pipeline and return data one cycle after grant.
module rf_host_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int AW            = AW_DEF,
  parameter int MAX_WAIT      = MAX_WAIT_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   dec_rs1,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_rs1,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            stall_req,
  input  logic            stall_ack,
  output logic            err
);

  arb_state_t state, next_state;

  logic wait_en, wait_clr, wait_tc;
  logic tmo_en, tmo_clr, tmo_tc;
  logic tmo_fire;
  logic host_fire_wr;
  logic read_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    dbg_gnt    = 1'b0;
    wait_en    = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (dbg_req) begin
          if (!dbg_we) begin
            next_state = STALL;
          end else if (!wb_we) begin
            dbg_gnt = 1'b1;
          end else begin
            next_state = WAIT;
            wait_en    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!dbg_req) begin
          next_state = IDLE;
        end else if (!wb_we) begin
          dbg_gnt    = 1'b1;
          next_state = IDLE;
        end else begin
          wait_en = 1'b1;
          if (wait_tc) begin
            next_state = STALL;
          end
        end
      end
      STALL: begin
        if (!dbg_req) begin
          next_state = RESP;
        end else if (stall_ack) begin
          next_state = ACCESS;
        end else if (tmo_tc) begin
          // Request is left pending; the host sees err and decides whether to retry.
          tmo_fire   = 1'b1;
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (!dbg_req) begin
          next_state = RESP;
        end else if (!wb_we) begin
          dbg_gnt    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Entering WAIT from IDLE counts as the first wait cycle.
  assign wait_clr = (state != WAIT) && !wait_en;
  assign tmo_en   = (state == STALL) && dbg_req && !stall_ack;
  assign tmo_clr  = (state != STALL);

  rf_arb_wait_ctr #(.MAX(MAX_WAIT)) u_wait_ctr (
    .clk (clk),
    .rst (rst),
    .clr (wait_clr),
    .en  (wait_en),
    .tc  (wait_tc)
  );

  rf_arb_wait_ctr #(.MAX(STALL_TIMEOUT)) u_tmo_ctr (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  // Host writes to x0 are acknowledged but never reach the register file.
  assign host_fire_wr = dbg_gnt && dbg_we && (dbg_addr != '0);
  assign read_gnt     = dbg_gnt && !dbg_we && (state == ACCESS);

  assign rf_we    = wb_we | host_fire_wr;
  assign rf_waddr = host_fire_wr ? dbg_addr  : wb_rd;
  assign rf_wdata = host_fire_wr ? dbg_wdata : wb_data;
  assign rf_rs1   = ((state == ACCESS) && !dbg_we) ? dbg_addr : dec_rs1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_req  <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      err        <= 1'b0;
    end else begin
      stall_req  <= (next_state == STALL) || (next_state == ACCESS);
      dbg_rvalid <= read_gnt;
      if (read_gnt) begin
        dbg_rdata <= rf_rdata1;
      end
      err <= err | tmo_fire;
    end
  end

endmodule

// File: tb/tb_rf_host_arbiter.sv
// Directed bench for rf_host_arbiter: vector table for the write-port mux, then
// hand-written conflict, starvation, read, timeout and reset sequences.
module tb_rf_host_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dec_rs1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_rdata1;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        stall_req;
  logic        stall_ack;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  rf_host_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .dec_rs1    (dec_rs1),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_rs1     (rf_rs1),
    .rf_rdata1  (rf_rdata1),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .stall_req  (stall_req),
    .stall_ack  (stall_ack),
    .err        (err)
  );

  // Register file model driven by the arbiter's write and read ports.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = rf_mem[rf_rs1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dec_rs1;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [4:0]  e_rs1;
    logic        e_gnt;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = d;
  endtask

  task automatic host(input logic req, input logic we, input logic [4:0] a, input logic [31:0] d);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
  endtask

  initial begin
    int gnt_cnt;
    rst       = 1'b0;
    stall_ack = 1'b0;
    dec_rs1   = 5'd0;
    wb(1'b0, 5'd0, 32'h0);
    host(1'b0, 1'b0, 5'd0, 32'h0);

    //                wb_we rd     data           rs1    req   we    addr    wdata          e_we  e_addr  e_wdata        e_rs1  e_gnt
    vt[0] = '{1'b0, 5'd4,  32'h0000_0044, 5'd9,  1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd4,  32'h0000_0044, 5'd9,  1'b0};
    vt[1] = '{1'b1, 5'd3,  32'h0000_1234, 5'd2,  1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'h0000_1234, 5'd2,  1'b0};
    vt[2] = '{1'b0, 5'd2,  32'h0000_0055, 5'd1,  1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd1,  1'b1};
    vt[3] = '{1'b0, 5'd6,  32'h0000_0066, 5'd0,  1'b1, 1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd6,  32'h0000_0066, 5'd0,  1'b1};
    vt[4] = '{1'b0, 5'd1,  32'h0000_0011, 5'd31, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 1'b1};
    vt[5] = '{1'b1, 5'd0,  32'h0000_CAFE, 5'd7,  1'b0, 1'b1, 5'd12, 32'h0000_0BAD, 1'b1, 5'd0,  32'h0000_CAFE, 5'd7,  1'b0};

    #2;
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_rvalid",    32'(dbg_rvalid), 32'd0);
    chk("rst_rdata",     dbg_rdata, 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wb(vt[i].wb_we, vt[i].wb_rd, vt[i].wb_data);
      dec_rs1 = vt[i].dec_rs1;
      host(vt[i].dbg_req, vt[i].dbg_we, vt[i].dbg_addr, vt[i].dbg_wdata);
      #1;
      chk($sformatf("vec%0d_rf_we", i),    32'(rf_we),    32'(vt[i].e_we));
      chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vt[i].e_waddr));
      chk($sformatf("vec%0d_rf_wdata", i), rf_wdata,      vt[i].e_wdata);
      chk($sformatf("vec%0d_rf_rs1", i),   32'(rf_rs1),   32'(vt[i].e_rs1));
      chk($sformatf("vec%0d_gnt", i),      32'(dbg_gnt),  32'(vt[i].e_gnt));
    end
    @(negedge clk);
    wb(1'b0, 5'd0, 32'h0);
    host(1'b0, 1'b0, 5'd0, 32'h0);

    // Conflict: WB owns the port for 3 cycles, host write lands on the 4th.
    @(negedge clk);
    wb(1'b1, 5'd7, 32'h77);
    host(1'b1, 1'b1, 5'd7, 32'h1);
    #1;
    chk("t2_c0_gnt",   32'(dbg_gnt), 32'd0);
    chk("t2_c0_waddr", 32'(rf_waddr), 32'd7);
    chk("t2_c0_wdata", rf_wdata, 32'h77);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t2_c%0d_gnt", c), 32'(dbg_gnt), 32'd0);
    end
    @(negedge clk);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_c3_gnt",   32'(dbg_gnt), 32'd1);
    chk("t2_c3_we",    32'(rf_we), 32'd1);
    chk("t2_c3_wdata", rf_wdata, 32'h1);
    @(negedge clk);
    host(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_x7_final", rf_mem[7], 32'h1);

    // Starvation: WB never idles, stall forced once the wait budget is spent.
    @(negedge clk);
    wb(1'b1, 5'd8, 32'h88);
    host(1'b1, 1'b1, 5'd9, 32'h99);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("t3_c%0d_stall_lo", c), 32'(stall_req), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("t3_c8_stall_hi", 32'(stall_req), 32'd1);
    @(negedge clk);
    #1;
    chk("t3_c9_gnt", 32'(dbg_gnt), 32'd0);
    @(negedge clk);
    stall_ack = 1'b1;
    #1;
    chk("t3_c10_gnt", 32'(dbg_gnt), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_defer_gnt",   32'(dbg_gnt), 32'd0);
    chk("t3_defer_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_gnt",   32'(dbg_gnt), 32'd1);
    chk("t3_waddr", 32'(rf_waddr), 32'd9);
    chk("t3_wdata", rf_wdata, 32'h99);
    @(negedge clk);
    host(1'b0, 1'b0, 5'd0, 32'h0);
    stall_ack = 1'b0;
    #1;
    chk("t3_resp_stall",  32'(stall_req), 32'd0);
    chk("t3_resp_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("t3_x9",          rf_mem[9], 32'h99);

    // Read of x3 (loaded to 0x1234 by vector 1).
    @(negedge clk);
    dec_rs1 = 5'd1;
    host(1'b1, 1'b0, 5'd3, 32'h0);
    #1;
    chk("t4_idle_rs1", 32'(rf_rs1), 32'd1);
    @(negedge clk);
    stall_ack = 1'b1;
    #1;
    chk("t4_stall_req", 32'(stall_req), 32'd1);
    @(negedge clk);
    #1;
    chk("t4_rs1", 32'(rf_rs1), 32'd3);
    chk("t4_gnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk);
    host(1'b0, 1'b0, 5'd0, 32'h0);
    stall_ack = 1'b0;
    #1;
    chk("t4_rvalid",   32'(dbg_rvalid), 32'd1);
    chk("t4_rdata",    dbg_rdata, 32'h1234);
    chk("t4_stall_lo", 32'(stall_req), 32'd0);
    @(negedge clk);
    #1;
    chk("t4_rvalid_pulse", 32'(dbg_rvalid), 32'd0);
    chk("t4_rdata_held",   dbg_rdata, 32'h1234);

    // Timeout: no ack for 64 stall cycles.
    @(negedge clk);
    host(1'b1, 1'b0, 5'd4, 32'h0);
    gnt_cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      #1;
      if (dbg_gnt) gnt_cnt++;
    end
    chk("t5_pre_err",   32'(err), 32'd0);
    chk("t5_pre_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    host(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t5_err",      32'(err), 32'd1);
    chk("t5_stall_lo", 32'(stall_req), 32'd0);
    chk("t5_no_gnt",   32'(gnt_cnt), 32'd0);

    // Reset in STALL, then the host reissues the read.
    @(negedge clk);
    host(1'b1, 1'b0, 5'd3, 32'h0);
    @(negedge clk);
    #1;
    chk("t6_stall_hi", 32'(stall_req), 32'd1);
    chk("t6_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    host(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t6_rst_stall",  32'(stall_req), 32'd0);
    chk("t6_rst_err",    32'(err), 32'd0);
    chk("t6_rst_rdata",  dbg_rdata, 32'd0);
    chk("t6_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("t6_rst_gnt",    32'(dbg_gnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    host(1'b1, 1'b0, 5'd3, 32'h0);
    @(negedge clk);
    stall_ack = 1'b1;
    #1;
    chk("t6_re_stall", 32'(stall_req), 32'd1);
    @(negedge clk);
    #1;
    chk("t6_re_gnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk);
    host(1'b0, 1'b0, 5'd0, 32'h0);
    stall_ack = 1'b0;
    #1;
    chk("t6_re_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("t6_re_rdata",  dbg_rdata, 32'h1234);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
